// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake: head entry of the fetch buffer offered under valid/ready.
interface instruction_fetch_unit_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   modport master (output out_valid, output out_inst, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: walks the PC through a combinational text memory into a 2-entry buffer,
// with flushing redirects and a sticky halt on misaligned targets.
module instruction_fetch_unit #(
   parameter int unsigned ADDR_BITS = 16,
   parameter logic [31:0] RESET_PC  = 32'h0040_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [ADDR_BITS-3:0] imem_address,
   input  logic [31:0]          imem_q,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic                 misaligned,
   instruction_fetch_unit_if.master dec
);

   typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] pc_buf   [2];
   logic [31:0] inst_buf [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;
   logic        pop;
   logic        push;
   logic        aligned;
   logic        has_entry;

   assign aligned      = (redirect_pc[1:0] == 2'b00);
   assign has_entry    = (count != 2'd0);
   assign pop          = has_entry && dec.out_ready;
   // A full buffer may still accept a new word when the head leaves in the same cycle.
   assign push         = (state == StFetch) && !redirect_valid && ((count != 2'd2) || pop);
   assign imem_address = fetch_pc[ADDR_BITS-1:2];

   assign dec.out_valid = has_entry;
   assign dec.out_pc    = has_entry ? pc_buf[head]   : 32'd0;
   assign dec.out_inst  = has_entry ? inst_buf[head] : 32'd0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= StBoot;
         fetch_pc   <= RESET_PC;
         head       <= 1'b0;
         tail       <= 1'b0;
         count      <= 2'd0;
         misaligned <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            pc_buf[i]   <= 32'd0;
            inst_buf[i] <= 32'd0;
         end
      end else begin
         case (state)
            StBoot: begin
               if (redirect_valid && !aligned) begin
                  misaligned <= 1'b1;
                  state      <= StHalt;
               end else begin
                  if (redirect_valid) fetch_pc <= redirect_pc;
                  state <= StFetch;
               end
            end
            StFetch: begin
               if (redirect_valid) begin
                  // Redirect beats push and pop; any entry decode took this cycle is gone anyway.
                  head  <= 1'b0;
                  tail  <= 1'b0;
                  count <= 2'd0;
                  if (!aligned) begin
                     misaligned <= 1'b1;
                     state      <= StHalt;
                  end else begin
                     fetch_pc <= redirect_pc;
                  end
               end else begin
                  if (push) begin
                     pc_buf[tail]   <= fetch_pc;
                     inst_buf[tail] <= imem_q;
                     tail           <= ~tail;
                     fetch_pc       <= fetch_pc + 32'd4;
                  end
                  if (pop) head <= ~head;
                  if (push && !pop)      count <= count + 2'd1;
                  else if (pop && !push) count <= count - 2'd1;
               end
            end
            StHalt: begin
               count <= 2'd0;
            end
            default: state <= StHalt;
         endcase
      end
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, meaning the byte-address width of the text memory; it matches the text memory's `TEXT_BITS.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imem_address, output, ADDR_BITS-2 bits: word address to the text memory, equal to fetch_pc[ADDR_BITS-1:2].
REQ-006 SHALL have port imem_q, input, 32 bits: instruction word returned combinationally for imem_address.
REQ-007 SHALL have port redirect_valid, input, 1 bit: a branch or jump redirect request from execute.
REQ-008 SHALL have port redirect_pc, input, 32 bits: the target byte address, sampled when redirect_valid=1.
REQ-009 SHALL have port out_valid, output, 1 bit: a fetched instruction is available to decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head entry this cycle.
REQ-011 SHALL have port out_inst, output, 32 bits: the instruction word of the head entry.
REQ-012 SHALL have port out_pc, output, 32 bits: the byte PC of the head entry.
REQ-013 SHALL have port misaligned, output, 1 bit: sticky flag set by a redirect whose target is not word-aligned.

Function
REQ-014 SHALL implement three FSM states: BOOT, FETCH and HALT.
REQ-015 SHALL spend exactly one cycle in BOOT after reset deasserts, with no buffer write, then go to FETCH; this lets the memory's reset gating clear.
REQ-016 SHALL contain a 2-entry FIFO of {pc, inst} pairs, with head pointer, tail pointer and a 2-bit count.
REQ-017 SHALL push in FETCH when there is no redirect and either count<2, or count==2 and a pop occurs in the same cycle; the pushed entry is {fetch_pc, imem_q}.
REQ-018 SHALL advance fetch_pc by 4 on every push, with modulo-2^32 wrap; imem_address wraps modulo the memory size through bit truncation.
REQ-019 SHALL pop when out_valid && out_ready; simultaneous push and pop leave count unchanged.
REQ-020 SHALL drive out_valid = (count != 0), and drive out_inst and out_pc from the head entry; both are 0 when count==0.
REQ-021 SHALL keep out_inst and out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL give a redirect in FETCH with redirect_pc[1:0]==0 priority over push and pop: flush the FIFO (count=0), set fetch_pc=redirect_pc, push nothing that cycle, and fetch the target on the next cycle.
REQ-023 SHALL give a redirect latency of 2 cycles from the redirect edge to out_valid=1 with out_pc=redirect_pc.
REQ-024 SHALL handle a redirect with redirect_pc[1:0]!=0 (in any state except HALT) by flushing the FIFO, setting misaligned=1, and entering HALT.
REQ-025 SHALL, in HALT, make no pushes, ignore redirects, hold out_valid=0, and stay until reset.
REQ-026 SHALL act on a redirect received during BOOT (aligned: load fetch_pc and then enter FETCH normally); it is not ignored.
REQ-027 SHALL give a plain fetch latency of 1 cycle from the push edge to out_valid=1.
REQ-028 SHALL sustain a throughput of one instruction per cycle when out_ready is held at 1.

Reset
REQ-029 SHALL, on reset assertion, asynchronously set: state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0, misaligned=0, out_valid=0, out_inst=0, out_pc=0.
REQ-030 SHALL, on reset assertion mid-operation, discard all buffered entries and any pending redirect; no partial state survives.

Verification
REQ-031 SHALL cover boot: memory words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193, out_ready=1 -> out_valid rises on the 2nd edge after reset deasserts; out_pc sequence 0x00400000,0x00400004,0x00400008,... with matching instructions, one per cycle.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles -> count saturates at 2, fetch_pc stops at RESET_PC+8, head stays 0x00400000/0x00000013; after release, no entry is duplicated or lost.
REQ-033 SHALL cover redirect: redirect_valid=1 with redirect_pc=0x00400040 while count=2 -> next cycle out_valid=0; following cycle out_pc=0x00400040 carrying the instruction at word 16.
REQ-034 SHALL cover simultaneous events: a redirect in the same cycle as out_ready=1 and FIFO non-empty -> the redirect wins; the popped entry is consumed, and no stale entry appears afterwards.
REQ-035 SHALL cover misaligned redirect: redirect_pc=0x00400042 -> misaligned=1, out_valid=0, HALT held for 10 cycles despite further aligned redirects; reset clears misaligned.
REQ-036 SHALL cover reset mid-stream: assert reset asynchronously with count=2 -> out_valid=0 immediately, without waiting for a clock edge; after release, fetch restarts at 0x00400000.
